// File: rtl/ctl_ammo_mag.sv
// rtl/ctl_ammo_mag.sv - magazine/reserve ammunition controller with timed reload and BCD HUD outputs
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   reset_score  synchronous restart, same effect as reset
//   shot_fired   trigger level; a rising edge is one shot attempt
//   reload_req   level request for a manual reload
//   shot_ok      one-cycle pulse per accepted shot
//   reloading    high while the reload timer runs
//   no_ammo      magazine and reserve both empty
//   mag_bcd      {tens, units} of the magazine count
//   res_bcd      {tens, units} of the reserve count

module ctl_ammo_mag #(
    parameter int MAG_SIZE      = 16,
    parameter int RESERVE       = 48,
    parameter int RELOAD_CYCLES = 65_000_000,
    parameter int AUTO_RELOAD   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reset_score,
    input  logic       shot_fired,
    input  logic       reload_req,
    output logic       shot_ok,
    output logic       reloading,
    output logic       no_ammo,
    output logic [7:0] mag_bcd,
    output logic [7:0] res_bcd
);

    localparam int             TW       = $clog2(RELOAD_CYCLES + 1);
    localparam logic [6:0]     MAG_FULL = 7'(MAG_SIZE);
    localparam logic [6:0]     RES_INIT = 7'(RESERVE);
    localparam logic [TW-1:0]  T_LOAD   = TW'(RELOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_RELOAD = 2'd1,
        ST_EMPTY  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [6:0]    mag_q, mag_d;
    logic [6:0]    res_q, res_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          shot_last_q;
    logic          shot_ok_q, shot_ok_d;
    logic          reloading_q;
    logic          no_ammo_q;
    logic [7:0]    mag_bcd_q;
    logic [7:0]    res_bcd_q;

    logic          shot_edge;
    logic [6:0]    room;
    logic [6:0]    xfer;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign shot_edge = shot_fired & ~shot_last_q;

    // Rounds moved on reload: limited by both free slots and what the reserve holds.
    assign room = MAG_FULL - mag_q;
    assign xfer = (room < res_q) ? room : res_q;

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        res_d     = res_q;
        timer_d   = timer_q;
        shot_ok_d = 1'b0;
        case (state_q)
            ST_READY: begin
                if (shot_edge && (mag_q != 7'd0)) begin
                    mag_d     = mag_q - 7'd1;
                    shot_ok_d = 1'b1;
                    if (mag_q == 7'd1) begin
                        if (res_q == 7'd0) begin
                            state_d = ST_EMPTY;
                        end else if (AUTO_RELOAD != 0) begin
                            state_d = ST_RELOAD;
                            timer_d = T_LOAD;
                        end
                    end
                end else if (!shot_edge && reload_req && (mag_q < MAG_FULL) && (res_q != 7'd0)) begin
                    // A shot edge wins the cycle; a held request is taken up next cycle.
                    state_d = ST_RELOAD;
                    timer_d = T_LOAD;
                end
            end
            ST_RELOAD: begin
                if (timer_q == '0) begin
                    mag_d   = mag_q + xfer;
                    res_d   = res_q - xfer;
                    state_d = ST_READY;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_EMPTY: begin
                state_d = ST_EMPTY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_READY;
            mag_q       <= MAG_FULL;
            res_q       <= RES_INIT;
            timer_q     <= '0;
            shot_last_q <= 1'b0;
            shot_ok_q   <= 1'b0;
            reloading_q <= 1'b0;
            no_ammo_q   <= 1'b0;
            mag_bcd_q   <= 8'h00;
            res_bcd_q   <= 8'h00;
        end else if (reset_score) begin
            state_q     <= ST_READY;
            mag_q       <= MAG_FULL;
            res_q       <= RES_INIT;
            timer_q     <= '0;
            shot_last_q <= 1'b0;
            shot_ok_q   <= 1'b0;
            reloading_q <= 1'b0;
            no_ammo_q   <= 1'b0;
            mag_bcd_q   <= 8'h00;
            res_bcd_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            res_q       <= res_d;
            timer_q     <= timer_d;
            shot_last_q <= shot_fired;
            shot_ok_q   <= shot_ok_d;
            reloading_q <= (state_d == ST_RELOAD);
            no_ammo_q   <= (mag_d == 7'd0) && (res_d == 7'd0);
            // Digits trail the counters by one cycle.
            mag_bcd_q   <= to_bcd(mag_q);
            res_bcd_q   <= to_bcd(res_q);
        end
    end

    assign shot_ok   = shot_ok_q;
    assign reloading = reloading_q;
    assign no_ammo   = no_ammo_q;
    assign mag_bcd   = mag_bcd_q;
    assign res_bcd   = res_bcd_q;

endmodule
